// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared constants and FSM state type for the auto-baud tick source
package baud_pkg;

   // Default divisor/counter width, post-reset divisor and smallest legal divisor
   localparam int BAUD_DW          = 16;
   localparam int BAUD_DEFAULT_DIV = 208;
   localparam int BAUD_MIN_DIV     = 2;

   // 16x oversampling: a start-bit length divided by 16 gives the divisor,
   // adding half of 16 first rounds to nearest
   localparam int OVERSAMPLE = 16;
   localparam int OVS_SHIFT  = 4;
   localparam int ROUND_ADD  = OVERSAMPLE / 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_MEASURE
   } ab_state_t;

endpackage

// File: rtl/baud_tick_counter.sv
// rtl/baud_tick_counter.sv - programmable mod-div counter producing the 16x oversampling tick
module baud_tick_counter
   import baud_pkg::*;
#(
   parameter int DW          = BAUD_DW,
   parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic [DW-1:0] load_val,
   output logic          tick,
   output logic [DW-1:0] div
);

   logic [DW-1:0] cnt;

   // Tick is the last count of the period; decoded from registers only
   assign tick = (cnt == (div - DW'(1)));

   // Divisor load restarts the phase so a full period always precedes the next tick
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div <= DW'(DEFAULT_DIV);
         cnt <= '0;
      end else if (load) begin
         div <= load_val;
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DW'(1);
      end
   end

endmodule

// File: rtl/autobaud_ctrl.sv
// rtl/autobaud_ctrl.sv - baud tick source with manual divisor and start-bit auto-baud (AUTOBAUD_EN)
module autobaud_ctrl
   import baud_pkg::*;
#(
   parameter int DW          = BAUD_DW,
   parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV,
   parameter int MIN_DIV     = BAUD_MIN_DIV
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          rx,
   input  logic          start,
   input  logic          cfg_we,
   input  logic [DW-1:0] cfg_div,
   output logic          tick,
   output logic [DW-1:0] div,
   output logic          busy,
   output logic          locked,
   output logic          err
);

   logic          cfg_ok;
   logic          load;
   logic [DW-1:0] load_val;

   assign cfg_ok = (cfg_div >= DW'(MIN_DIV));

`ifdef AUTOBAUD_EN

   logic           sync1;
   logic           rxs;
   logic           rxs_d;
   logic           rx_fall;
   logic           rx_rise;
   ab_state_t      state;
   logic [DW+3:0]  mcnt;
   logic [DW+4:0]  msum;
   logic [DW:0]    q_wide;
   logic           q_ok;
   logic           meas_load;

   assign rx_fall = rxs_d & ~rxs;
   assign rx_rise = ~rxs_d & rxs;

   // Round-to-nearest start-bit length / 16; an overflow past DW bits is not a usable divisor
   assign msum   = {1'b0, mcnt} + (DW+5)'(ROUND_ADD);
   assign q_wide = msum[DW+4:OVS_SHIFT];
   assign q_ok   = !q_wide[DW] && (q_wide >= (DW+1)'(MIN_DIV));

   // A host write always wins over a measurement finishing in the same cycle
   assign meas_load = (state == ST_MEASURE) && rx_rise && q_ok && !cfg_we;
   assign load      = (cfg_we && cfg_ok) || meas_load;
   assign load_val  = cfg_we ? cfg_div : q_wide[DW-1:0];

   // Two-flop synchronizer for the asynchronous line plus one history flop for edge detect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         sync1 <= rx;
         rxs   <= sync1;
         rxs_d <= rxs;
      end
   end

   // Measurement FSM with registered status flags; host write aborts and takes priority
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         mcnt   <= '0;
         busy   <= 1'b0;
         locked <= 1'b0;
         err    <= 1'b0;
      end else if (cfg_we) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         if (cfg_ok) begin
            locked <= 1'b0;
            err    <= 1'b0;
         end else begin
            err    <= 1'b1;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_ARMED;
                  busy  <= 1'b1;
                  err   <= 1'b0;
               end
            end
            ST_ARMED: begin
               if (rx_fall) begin
                  state <= ST_MEASURE;
                  mcnt  <= (DW+4)'(1);
               end
            end
            ST_MEASURE: begin
               if (rx_rise) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  if (q_ok) begin
                     locked <= 1'b1;
                     err    <= 1'b0;
                  end else begin
                     err    <= 1'b1;
                  end
               end else if (&mcnt) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else if (!rxs) begin
                  mcnt <= mcnt + (DW+4)'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`else

   logic unused_inputs;

   assign unused_inputs = rx ^ start;
   assign busy          = 1'b0;
   assign locked        = 1'b0;
   assign load          = cfg_we && cfg_ok;
   assign load_val      = cfg_div;

   // Sticky flag for illegal manual divisors; a legal write clears it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err <= 1'b0;
      end else if (cfg_we) begin
         err <= !cfg_ok;
      end
   end

`endif

   baud_tick_counter #(
      .DW          (DW),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_tick_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .load_val (load_val),
      .tick     (tick),
      .div      (div)
   );

endmodule

// File: tb/tb_autobaud_ctrl.sv
// tb/tb_autobaud_ctrl.sv - directed self-checking bench for autobaud_ctrl
module tb_autobaud_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        rx;
   logic        start;
   logic        cfg_we;
   logic [15:0] cfg_div;
   logic        tick;
   logic [15:0] div;
   logic        busy;
   logic        locked;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;
   int n;

   autobaud_ctrl #(
      .DW          (16),
      .DEFAULT_DIV (208),
      .MIN_DIV     (2)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rx      (rx),
      .start   (start),
      .cfg_we  (cfg_we),
      .cfg_div (cfg_div),
      .tick    (tick),
      .div     (div),
      .busy    (busy),
      .locked  (locked),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Index (1-based, one per negedge) of the first sampled cycle with tick high; 0 if none
   task automatic measure_tick(output int idx, input int limit);
      idx = 0;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (tick) begin
            idx = i;
            break;
         end
      end
   endtask

   task automatic write_div(input logic [15:0] v);
      @(negedge clk);
      cfg_we  = 1'b1;
      cfg_div = v;
      @(posedge clk);
      #1;
      cfg_we  = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      rx      = 1'b1;
      start   = 1'b0;
      cfg_we  = 1'b0;
      cfg_div = '0;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_div", div, 208);
      check_eq("rst_tick", tick, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_locked", locked, 0);
      check_eq("rst_err", err, 0);

      reset_n = 1'b1;
      measure_tick(n, 300);
      check_eq("first_tick_208", n, 208);
      measure_tick(n, 300);
      check_eq("tick_period_208", n, 208);

      write_div(16'd5);
      check_eq("wr5_div", div, 5);
      check_eq("wr5_err", err, 0);
      measure_tick(n, 20);
      check_eq("wr5_first_tick", n, 5);
      measure_tick(n, 20);
      check_eq("wr5_period", n, 5);

      write_div(16'd1);
      check_eq("wr1_div_kept", div, 5);
      check_eq("wr1_err", err, 1);

      write_div(16'd2);
      check_eq("wr2_min_div", div, 2);
      check_eq("wr2_err_clr", err, 0);
      measure_tick(n, 10);
      check_eq("wr2_first_tick", n, 2);

`ifdef AUTOBAUD_EN
      // Full calibration: 1664 low cycles -> (1664+8)>>4 = 104
      pulse_start();
      check_eq("cal_busy", busy, 1);
      repeat (5) @(negedge clk);
      rx = 1'b0;
      repeat (1664) @(negedge clk);
      rx = 1'b1;
      @(negedge clk);
      check_eq("cal_busy_p1", busy, 1);
      @(negedge clk);
      check_eq("cal_busy_p2", busy, 1);
      @(negedge clk);
      check_eq("cal_busy_p3", busy, 0);
      check_eq("cal_div", div, 104);
      check_eq("cal_locked", locked, 1);
      check_eq("cal_err", err, 0);
      measure_tick(n, 200);
      check_eq("cal_first_tick", n, 103);
      measure_tick(n, 200);
      check_eq("cal_period", n, 104);

      // Too-short start bit: (20+8)>>4 = 1 < MIN_DIV
      pulse_start();
      check_eq("short_busy", busy, 1);
      repeat (3) @(negedge clk);
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      wait_idle(20);
      check_eq("short_idle", busy, 0);
      check_eq("short_err", err, 1);
      check_eq("short_div", div, 104);
      check_eq("short_locked", locked, 1);

      pulse_start();
      check_eq("restart_err_clr", err, 0);
      check_eq("restart_busy", busy, 1);

      // Host write aborts an in-progress measurement
      repeat (3) @(negedge clk);
      rx = 1'b0;
      repeat (100) @(negedge clk);
      check_eq("abort_pre_busy", busy, 1);
      write_div(16'd50);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_div", div, 50);
      check_eq("abort_locked", locked, 0);
      @(negedge clk);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      check_eq("abort_late_div", div, 50);
      check_eq("abort_late_busy", busy, 0);

      // Write and start together in IDLE: write wins, start ignored
      @(negedge clk);
      cfg_we  = 1'b1;
      cfg_div = 16'd60;
      start   = 1'b1;
      @(posedge clk);
      #1;
      cfg_we  = 1'b0;
      start   = 1'b0;
      check_eq("both_div", div, 60);
      check_eq("both_busy", busy, 0);

      // Asynchronous reset in the middle of a measurement
      pulse_start();
      repeat (3) @(negedge clk);
      rx = 1'b0;
      repeat (30) @(negedge clk);
      check_eq("rstm_pre_busy", busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("rstm_div", div, 208);
      check_eq("rstm_busy", busy, 0);
      check_eq("rstm_err", err, 0);
      check_eq("rstm_tick", tick, 0);
      @(negedge clk);
      reset_n = 1'b1;
      rx = 1'b1;
      repeat (6) @(negedge clk);
      rx = 1'b0;
      repeat (40) @(negedge clk);
      rx = 1'b1;
      repeat (6) @(negedge clk);
      check_eq("post_rst_busy", busy, 0);
      check_eq("post_rst_div", div, 208);
      check_eq("post_rst_locked", locked, 0);
`else
      // Auto-baud removed: start and rx have no effect
      pulse_start();
      check_eq("noab_busy", busy, 0);
      rx = 1'b0;
      repeat (40) @(negedge clk);
      rx = 1'b1;
      repeat (6) @(negedge clk);
      check_eq("noab_div", div, 2);
      check_eq("noab_locked", locked, 0);
      check_eq("noab_busy2", busy, 0);

      write_div(16'd60);
      check_eq("noab_wr60", div, 60);
      write_div(16'd0);
      check_eq("noab_wr0_err", err, 1);
      check_eq("noab_wr0_div", div, 60);

      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("rstm_div", div, 208);
      check_eq("rstm_err", err, 0);
      check_eq("rstm_tick", tick, 0);
      @(negedge clk);
      reset_n = 1'b1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
